mem_port_arbiter: RTL and testbench

//  Shares the core's single memory port between instruction fetch (icache refill) and data (load/store) requesters.

---
 rtl/core_pkg.sv | 6 +
 rtl/mem_arb_pick.sv | 19 +
 rtl/mem_port_arbiter.sv | 67 ++++++
 tb/tb_mem_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the memory port arbiter
package core_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP} arb_state_t;
  localparam logic ARB_OWN_FETCH = 1'b0;
  localparam logic ARB_OWN_DATA = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-first winner selection with a streak limit that lets fetch through
module mem_arb_pick #(
  parameter int MAX_STREAK = 4
) (
  input  logic CLK,
  input  logic resetn,
  input  logic i_req,
  input  logic d_req,
  input  logic grant,
  output logic pick_data
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] MAX = SW'(MAX_STREAK);
  logic [SW-1:0] streak;
  assign pick_data = d_req && !(i_req && streak == MAX);
  always_ff @(posedge CLK)
    if (!resetn) streak <= '0;
    else if (grant) streak <= (pick_data && i_req) ? ((streak == MAX) ? MAX : streak + 1'b1) : '0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, one transaction at a time
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic          CLK,
  input  logic          resetn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  arb_state_t state;
  logic owner, pick_data, grant, resp;
  assign grant = resetn && state == ARB_IDLE && (i_req || d_req);
  mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .CLK(CLK), .resetn(resetn), .i_req(i_req), .d_req(d_req), .grant(grant), .pick_data(pick_data)
  );
  // gating with resetn keeps a reset cycle from leaking a grant or a response
  assign resp = resetn && state == ARB_RESP && mem_rvalid;
  assign i_gnt = grant && !pick_data;
  assign d_gnt = grant && pick_data;
  assign i_rvalid = resp && owner == ARB_OWN_FETCH;
  assign d_rvalid = resp && owner == ARB_OWN_DATA;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;
  assign mem_req = state == ARB_REQ;
  assign busy = state != ARB_IDLE;
  always_ff @(posedge CLK)
    if (!resetn) begin
      state <= ARB_IDLE;
      owner <= ARB_OWN_FETCH;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
    end else if (grant) begin
      state <= ARB_REQ;
      owner <= pick_data ? ARB_OWN_DATA : ARB_OWN_FETCH;
      mem_we <= pick_data && d_we;
      mem_addr <= pick_data ? d_addr : i_addr;
      mem_wdata <= pick_data ? d_wdata : '0;
      mem_be <= (pick_data && d_we) ? d_be : '1;
    end else if (state == ARB_REQ && mem_ready) state <= ARB_RESP;
    else if (resp) state <= ARB_IDLE;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with requester and memory agents
module tb_mem_port_arbiter;
  import core_pkg::*;
  logic CLK = 0, resetn = 0;
  logic i_req, i_gnt, i_rvalid, d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic [3:0] d_be, mem_be;
  logic mem_req, mem_we, mem_ready, mem_rvalid, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  always #5 CLK = ~CLK;
  mem_port_arbiter dut (
    .CLK(CLK), .resetn(resetn),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy)
  );
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be;} bus_t;
  typedef struct packed {logic own; logic [31:0] data;} rsp_t;
  logic gnt_q[$];
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  int checks = 0, errors = 0, cyc = 0, t_gnt_i = 0, t_gnt_d = 0, t_rv = 0;
  int i_left = 0, d_left = 0, ready_dly = 0, rvalid_dly = 0;
  logic [31:0] i_addr_v = 0, d_addr_v = 0, d_wdata_v = 0, rdata_v = 0;
  logic d_we_v = 0, mem_auto = 1, junk_rv = 0;
  logic [3:0] d_be_v = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic push(logic own, logic [31:0] data);
    gnt_q.push_back(own);
    bus_q.push_back(own ? bus_t'{we: d_we_v, addr: d_addr_v, wdata: d_wdata_v, be: d_we_v ? d_be_v : 4'hF}
                        : bus_t'{we: 1'b0, addr: i_addr_v, wdata: 32'h0, be: 4'hF});
    rsp_q.push_back(rsp_t'{own: own, data: data});
  endtask
  task automatic drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (gnt_q.size() == 0 && bus_q.size() == 0 && rsp_q.size() == 0 && !busy && i_left == 0 && d_left == 0) break;
    end
    if (k == 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d grants, %0d responses still pending, required 0", gnt_q.size(), rsp_q.size());
    end
  endtask
  initial begin : fetch_agent
    logic g;
    i_req = 0;
    i_addr = 0;
    forever begin
      @(negedge CLK);
      g = i_gnt;
      @(posedge CLK);
      #1;
      if (g) i_left--;
      i_req = i_left > 0;
      i_addr = i_addr_v;
    end
  end
  initial begin : data_agent
    logic g;
    d_req = 0;
    d_we = 0;
    d_addr = 0;
    d_wdata = 0;
    d_be = 0;
    forever begin
      @(negedge CLK);
      g = d_gnt;
      @(posedge CLK);
      #1;
      if (g) d_left--;
      d_req = d_left > 0;
      d_we = d_we_v;
      d_addr = d_addr_v;
      d_wdata = d_wdata_v;
      d_be = d_be_v;
    end
  end
  initial begin : mem_agent
    int n;
    logic ph;
    n = 0;
    ph = 0;
    mem_ready = 0;
    mem_rvalid = 0;
    mem_rdata = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (mem_auto) begin
        mem_ready = 0;
        mem_rvalid = 0;
        if (mem_req) begin
          if (n >= ready_dly) begin
            mem_ready = 1;
            n = 0;
            ph = 1;
            if (junk_rv) begin
              mem_rvalid = 1;
              mem_rdata = 32'hBAD0BAD0;
            end
          end else n++;
        end else if (ph) begin
          if (n >= rvalid_dly) begin
            mem_rvalid = 1;
            mem_rdata = rdata_v;
            n = 0;
            ph = 0;
          end else n++;
        end
      end
    end
  end
  initial begin : monitor
    bus_t pb, e;
    rsp_t r;
    logic pr;
    pr = 0;
    pb = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      if (i_gnt || d_gnt) begin
        chk("gnt_onehot", {31'b0, i_gnt && d_gnt}, 32'h0);
        if (gnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL gnt_unexpected: got i_gnt=%b d_gnt=%b, required no grant", i_gnt, d_gnt);
        end else chk("gnt_owner", {31'b0, d_gnt}, {31'b0, gnt_q.pop_front()});
        if (i_gnt) t_gnt_i = cyc;
        if (d_gnt) t_gnt_d = cyc;
      end
      if (mem_req && pr) chk("bus_stable", {31'b0, {mem_we, mem_addr, mem_wdata, mem_be} == pb}, 32'h1);
      if (mem_req) chk("busy_in_req", {31'b0, busy}, 32'h1);
      if (mem_req && mem_ready) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL bus_unexpected: got addr %h, required no transaction", mem_addr);
        end else begin
          e = bus_q.pop_front();
          chk("bus_we", {31'b0, mem_we}, {31'b0, e.we});
          chk("bus_addr", mem_addr, e.addr);
          chk("bus_be", {28'b0, mem_be}, {28'b0, e.be});
          if (e.we) chk("bus_wdata", mem_wdata, e.wdata);
        end
      end
      pr = mem_req;
      pb = {mem_we, mem_addr, mem_wdata, mem_be};
      if (i_rvalid || d_rvalid) begin
        t_rv = cyc;
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got i_rvalid=%b d_rvalid=%b, required none", i_rvalid, d_rvalid);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_owner", {31'b0, d_rvalid}, {31'b0, r.own});
          chk("rsp_onehot", {31'b0, i_rvalid && d_rvalid}, 32'h0);
          chk("rsp_data", d_rvalid ? d_rdata : i_rdata, r.data);
        end
      end
    end
  end
  initial begin : main
    int k, n;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outputs", {27'b0, i_gnt, d_gnt, i_rvalid, d_rvalid, busy}, 32'h0);
    chk("rst_mem", {27'b0, mem_req, mem_we, mem_be}, 32'h0);
    chk("rst_mem_addr", mem_addr | mem_wdata, 32'h0);
    @(posedge CLK);
    #1 resetn = 1;
    @(negedge CLK);
    i_addr_v = 32'h40;
    rdata_v = 32'h00000013;
    push(ARB_OWN_FETCH, 32'h00000013);
    i_left = 1;
    drain();
    chk("fetch_latency", t_rv - t_gnt_i, 32'd2);
    d_we_v = 1;
    d_addr_v = 32'h100;
    d_wdata_v = 32'hDEADBEEF;
    d_be_v = 4'b0011;
    i_addr_v = 32'h44;
    rdata_v = 32'h55;
    push(ARB_OWN_DATA, 32'h55);
    push(ARB_OWN_FETCH, 32'h55);
    i_left = 1;
    d_left = 1;
    drain();
    chk("fetch_next_idle", t_gnt_i - t_gnt_d, 32'd3);
    d_we_v = 0;
    d_addr_v = 32'h200;
    i_addr_v = 32'h48;
    rdata_v = 32'h77;
    junk_rv = 1;
    for (int j = 0; j < 10; j++) push((j == 4 || j == 9) ? ARB_OWN_FETCH : ARB_OWN_DATA, 32'h77);
    i_left = 2;
    d_left = 8;
    drain();
    junk_rv = 0;
    ready_dly = 5;
    rvalid_dly = 7;
    d_we_v = 1;
    d_addr_v = 32'h300;
    d_wdata_v = 32'h12345678;
    d_be_v = 4'hC;
    rdata_v = 32'h0;
    push(ARB_OWN_DATA, 32'h0);
    d_left = 1;
    for (k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (d_gnt) break;
    end
    chk("stall_gnt_seen", {31'b0, k < 20}, 32'h1);
    n = 0;
    for (k = 0; k < 50; k++) begin
      @(negedge CLK);
      chk("stall_busy", {31'b0, busy}, 32'h1);
      n++;
      if (d_rvalid) break;
    end
    chk("stall_cycles", n, 32'd14);
    drain();
    ready_dly = 0;
    rvalid_dly = 0;
    mem_auto = 0;
    @(posedge CLK);
    #1 mem_rvalid = 1;
    mem_rdata = 32'hBAD1BAD1;
    @(negedge CLK);
    chk("spurious_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'h0);
    @(posedge CLK);
    #1 mem_rvalid = 0;
    i_addr_v = 32'h60;
    gnt_q.push_back(ARB_OWN_FETCH);
    bus_q.push_back(bus_t'{we: 1'b0, addr: 32'h60, wdata: 32'h0, be: 4'hF});
    i_left = 1;
    for (k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (i_gnt) break;
    end
    chk("reset_gnt_seen", {31'b0, k < 20}, 32'h1);
    @(posedge CLK);
    #1 mem_ready = 1;
    @(posedge CLK);
    #1 mem_ready = 0;
    resetn = 0;
    @(negedge CLK);
    chk("reset_in_resp", {30'b0, i_rvalid, d_rvalid}, 32'h0);
    @(posedge CLK);
    #1 resetn = 1;
    mem_rvalid = 1;
    mem_rdata = 32'hBAD2BAD2;
    @(negedge CLK);
    chk("post_rst_outputs", {27'b0, i_gnt, d_gnt, i_rvalid, d_rvalid, busy}, 32'h0);
    chk("post_rst_mem", {27'b0, mem_req, mem_we, mem_be}, 32'h0);
    chk("post_rst_mem_addr", mem_addr | mem_wdata, 32'h0);
    @(posedge CLK);
    #1 mem_rvalid = 0;
    mem_auto = 1;
    repeat (3) @(negedge CLK);
    chk("gnt_q_empty", gnt_q.size(), 32'h0);
    chk("bus_q_empty", bus_q.size(), 32'h0);
    chk("rsp_q_empty", rsp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
